// File: rtl/axis_to_rs232_buffered.sv
// axis_to_rs232_buffered: FIFO-buffered 8N1 UART transmitter with CTS flow control
module axis_to_rs232_buffered #(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_LOG2  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           idata,
    input  logic                 ivalid,
    output logic                 iready,
    output logic                 txd_pin,
    input  logic                 ctsn_pin,
    output logic [FIFO_LOG2:0]   level,
    output logic                 busy
);
    localparam int DIV = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
    localparam logic [FIFO_LOG2:0] FULL = {1'b1, {FIFO_LOG2{1'b0}}};

    generate
        if (DIV < 2) begin : g_div_check
            $error("bit period must be at least 2 clocks");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nx;
    logic [7:0]           mem [2**FIFO_LOG2];
    logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_LOG2:0]   count;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [2:0]           bit_idx, bit_idx_nx;
    logic [7:0]           sh, sh_nx;
    logic                 txd_nx;
    logic [1:0]           ctsn_sync;
    logic                 wr, pop, cts_ok, start_ok, expired;

    assign iready   = count != FULL;
    assign wr       = ivalid && iready;
    assign cts_ok   = !ctsn_sync[1];
    assign start_ok = (count != '0) && cts_ok;
    assign expired  = cnt == '0;
    assign level    = count;
    assign busy     = state != IDLE;

    // two-flop synchroniser for the asynchronous clear-to-send, idling at "not clear"
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ctsn_sync <= 2'b11;
        else
            ctsn_sync <= {ctsn_sync[0], ctsn_pin};
    end

    // FIFO storage, written only on accepted input bytes
    always_ff @(posedge clock) begin
        if (wr)
            mem[wr_ptr] <= idata;
    end

    // FIFO pointers and occupancy; pops happen only when a frame starts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr ? wr_ptr + FIFO_LOG2'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + FIFO_LOG2'(1) : rd_ptr;
            count  <= count + {{FIFO_LOG2{1'b0}}, wr} - {{FIFO_LOG2{1'b0}}, pop};
        end
    end

    // frame sequencing: start bit, eight data bits LSB first, stop bit, chained starts
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        sh_nx      = sh;
        txd_nx     = txd_pin;
        pop        = 1'b0;
        case (state)
            IDLE, STOP: begin
                if (state == IDLE || expired) begin
                    if (start_ok) begin
                        pop      = 1'b1;
                        sh_nx    = mem[rd_ptr];
                        txd_nx   = 1'b0;
                        cnt_nx   = DIV_M1;
                        state_nx = START;
                    end else begin
                        txd_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            START: begin
                if (expired) begin
                    txd_nx     = sh[0];
                    sh_nx      = sh >> 1;
                    bit_idx_nx = 3'd0;
                    cnt_nx     = DIV_M1;
                    state_nx   = DATA;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DATA: begin
                if (expired) begin
                    cnt_nx = DIV_M1;
                    if (bit_idx == 3'd7) begin
                        txd_nx   = 1'b1;
                        state_nx = STOP;
                    end else begin
                        txd_nx     = sh[0];
                        sh_nx      = sh >> 1;
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // frame state registers; the line is registered so it never glitches
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            txd_pin <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            sh      <= sh_nx;
            txd_pin <= txd_nx;
        end
    end
endmodule

// File: tb/tb_axis_to_rs232_buffered.sv
// tb_axis_to_rs232_buffered: randomized bench against a frame-level UART transmitter model
module tb_axis_to_rs232_buffered;
    logic       clock = 1'b0;
    logic       reset, ivalid, ctsn_pin;
    logic [7:0] idata;
    logic       iready, txd_pin, busy;
    logic [4:0] level;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    axis_to_rs232_buffered #(.CLOCK_FREQ(8000000), .BAUD_RATE(1000000), .FIFO_LOG2(4)) dut (
        .clock(clock), .reset(reset), .idata(idata), .ivalid(ivalid), .iready(iready),
        .txd_pin(txd_pin), .ctsn_pin(ctsn_pin), .level(level), .busy(busy)
    );

    always #5 clock = ~clock;

    // model: a byte queue plus the position within the frame on the line
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int         t = 0;
    bit         in_frame = 0;
    logic [1:0] hist = 2'b11;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            in_frame = 0;
            t = 0;
            hist = 2'b11;
        end else begin
            bit w, ok;
            w = ivalid && (q.size() != 16);
            ok = !hist[1];
            hist = {hist[0], ctsn_pin};
            if (in_frame) begin
                t = t + 1;
                if (t == 80) in_frame = 0;
            end
            if (!in_frame && q.size() != 0 && ok) begin
                cur = q.pop_front();
                in_frame = 1;
                t = 0;
            end
            if (w) q.push_back(idata);
        end
    end

    function automatic logic exp_txd();
        if (!in_frame) return 1'b1;
        if (t < 8) return 1'b0;
        if (t < 72) return cur[(t - 8) / 8];
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clock) begin
        if (chk_en) begin
            check("txd", txd_pin, exp_txd());
            check("busy", busy, in_frame);
            check("level", level, q.size());
            check("iready", iready, q.size() != 16);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [7:0] d);
        int g;
        bit acc;
        ivalid = 1'b1;
        idata = d;
        g = 0;
        do begin
            acc = iready;
            tick();
            g++;
        end while (!acc && g < 2000);
        ivalid = 1'b0;
        check("put_accept", acc, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_line;
        int n;
        a5_line = 10'b1101001010;
        reset = 1'b0;
        ivalid = 1'b0;
        idata = 8'h00;
        ctsn_pin = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk_en = 1;
        check("rst_txd", txd_pin, 1);
        check("rst_iready", iready, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;

        // single byte with CTS open
        ctsn_pin = 1'b0;
        repeat (4) tick();
        idata = 8'hA5;
        ivalid = 1'b1;
        tick();
        ivalid = 1'b0;
        check("a5_before_start", txd_pin, 1);
        tick();
        check("a5_latency", txd_pin, 0);
        for (int k = 0; k < 80; k++) begin
            check("a5_line", txd_pin, a5_line[k / 8]);
            check("a5_busy", busy, 1);
            tick();
        end
        check("a5_done_busy", busy, 0);
        check("a5_done_txd", txd_pin, 1);

        // fill with CTS blocked, 17 bytes offered
        ctsn_pin = 1'b1;
        repeat (3) tick();
        ivalid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            idata = 8'(i);
            tick();
            if (i == 15) check("fill_iready_drop", iready, 0);
        end
        ivalid = 1'b0;
        check("fill_level", level, 16);
        check("fill_iready", iready, 0);
        check("fill_txd", txd_pin, 1);

        // drain 16 contiguous frames
        ctsn_pin = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (txd_pin && n < 10);
        check("drain_cts_latency", n, 3);
        check("drain_iready_back", iready, 1);
        check("drain_level_first", level, 15);
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        check("drain_span", n, 1280);
        check("drain_level_end", level, 0);

        // CTS raised mid-frame with two bytes behind
        for (int i = 0; i < 3; i++) begin
            idata = 8'($urandom);
            ivalid = 1'b1;
            tick();
        end
        ivalid = 1'b0;
        repeat (33) tick();
        ctsn_pin = 1'b1;
        repeat (60) tick();
        check("cts_hold_txd", txd_pin, 1);
        check("cts_hold_busy", busy, 0);
        check("cts_hold_level", level, 2);
        ctsn_pin = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (txd_pin && n < 10);
        check("cts_resume", (n >= 1 && n <= 3), 1);
        n = 0;
        while ((busy || level != 0) && n < 400) begin
            tick();
            n++;
        end
        check("cts_drain", n < 400, 1);

        // reset during data bit 5 of a zero byte
        idata = 8'h00;
        ivalid = 1'b1;
        tick();
        idata = 8'($urandom);
        tick();
        idata = 8'($urandom);
        tick();
        ivalid = 1'b0;
        repeat (51) tick();
        check("pre_reset_bit5", txd_pin, 0);
        reset = 1'b1;
        #1;
        check("midrst_txd", txd_pin, 1);
        check("midrst_level", level, 0);
        check("midrst_busy", busy, 0);
        check("midrst_iready", iready, 1);
        repeat (2) tick();
        reset = 1'b0;

        // 40 random bytes in bursts of 10 across pointer wrap
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) put(8'($urandom));
            repeat ($urandom_range(50, 400)) tick();
        end
        n = 0;
        while ((busy || level != 0) && n < 5000) begin
            tick();
            n++;
        end
        check("wrap_drain", n < 5000, 1);
        check("wrap_txd_idle", txd_pin, 1);
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
